// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit adder that adds DIGIT bits per cycle, LSB first, with a registered carry.
// Define SERIAL_ADDER_SUB_EN to add the sub port, which selects a - b.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] dig_a, dig_b, dig_s;
    logic [DIGIT:0]   dig_full;
    logic             dig_cout;
    logic             dig_cmsb;
    logic             last_dig;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1, so cout=1 means no borrow.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    assign dig_a    = a_q[DIGIT-1:0];
    assign dig_b    = b_q[DIGIT-1:0];
    assign dig_full = {1'b0, dig_a} + {1'b0, dig_b} + {{DIGIT{1'b0}}, carry_q};
    assign dig_s    = dig_full[DIGIT-1:0];
    assign dig_cout = dig_full[DIGIT];
    // Carry into the top bit of this digit, recovered from its sum bit.
    assign dig_cmsb = dig_s[DIGIT-1] ^ dig_a[DIGIT-1] ^ dig_b[DIGIT-1];
    assign last_dig = (cnt_q == LAST_CNT);

    generate
        if (NDIG == 1) begin : g_res_one
            assign res_shift = dig_s;
        end else begin : g_res_shift
            assign res_shift = {dig_s, res_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_load;
                    carry_d = carry_load;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_shift;
                carry_d = dig_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                // Outputs change only here, so partial sums are never visible.
                if (last_dig) begin
                    sum_d   = res_shift;
                    cout_d  = dig_cout;
                    ovf_d   = dig_cmsb ^ dig_cout;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder built around a single DIGIT-bit full-adder slice with a registered carry, iterated LSB-first across a WIDTH-bit operand pair. It is the sequential, width-generic successor to the structural 1-bit full adder. It trades latency for area wherever a wide add is needed infrequently. A start/busy/done handshake lets it sit behind simple control FSMs.

## Interface
- WIDTH, 8: operand and sum width in bits; must be ≥ 2.
- DIGIT, 1: bits added per cycle; must divide WIDTH; NDIG = WIDTH/DIGIT.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while idle.
- a  input  WIDTH  operand A (unsigned or two's complement), captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- cin  input  1  carry-in, captured on accepted start.
- sub  input  1  subtract select, captured on accepted start; present only with SERIAL_ADDER_SUB_EN.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result; updates only on completion.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).

## Operation
- Reset: state IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal operand/shift registers, carry and digit counter cleared.
- States:
  - IDLE: if start=1, latch a, b and carry register ← cin, clear counter, go to RUN. Otherwise remain in IDLE.
  - RUN: each cycle adds the low DIGIT bits of the A and B shift registers plus the carry register. The resulting digit shifts into the top of the result shift register; A and B shift right by DIGIT; carry register ← digit carry-out; counter increments. After the digit with counter = NDIG-1, go to IDLE.
- Completion, on the edge that processes the last digit:
  - sum ← full result register;
  - cout ← final carry;
  - ovf ← carry into bit WIDTH-1 XOR final carry;
  - done ← 1 for exactly one cycle.
- sum/cout/ovf hold their value until the next completion or reset; they never expose partial results.
- start while busy=1 is ignored; no queuing.
- Arithmetic: result = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the exact sum.
- Reset asserted mid-operation aborts immediately; the aborted result is never presented.

## Timing
- Accepted start at edge E0; busy=1 from E0 until edge E_NDIG.
- Digit k is processed at edge E(k+1), for k = 0..NDIG-1.
- Latency: done=1 and result valid in the cycle after edge E_NDIG, i.e. NDIG cycles after the start edge; busy=0 in that same cycle.
- Back-to-back: start asserted during the done cycle is accepted, giving a throughput of one add per NDIG+1 cycles.
- NDIG=1 (DIGIT=WIDTH): single RUN cycle; done one cycle after start.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - sub port exists.
  - On accepted start with sub=1, B is captured inverted and the carry register is set to 1; cin is ignored. Result = a − b mod 2^WIDTH.
  - cout=1 means no borrow; ovf is signed subtraction overflow.
- Undefined: no sub port; always add.

## Test plan
- Reset mid-run, at cycle 3 of an 8-cycle add → busy=0, done never pulses, sum=0, cout=0, ovf=0.
- WIDTH=8, DIGIT=1, a=200, b=100, cin=0 → done exactly 8 cycles after start; sum=44, cout=1, ovf=0.
- WIDTH=8, DIGIT=1, a=100, b=50, cin=1 → sum=151 (0x97), cout=0, ovf=1.
- WIDTH=8, DIGIT=4, a=0xFF, b=0x00, cin=1 → done 2 cycles after start; sum=0x00, cout=1, ovf=0.
- Start pulsed again while busy, then in the done cycle → the busy-time start is ignored; the done-cycle start is accepted and its result appears NDIG cycles later.
- With SERIAL_ADDER_SUB_EN, a=5, b=7, sub=1 → sum=0xFE, cout=0, ovf=0; a=0x80, b=1, sub=1 → sum=0x7F, cout=1, ovf=1.
